// File: rtl/compositor_pkg.sv
// Shared types, colour constants and marker arithmetic helpers for pixel_compositor.
package compositor_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int VEC_W_DEF   = 8;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef logic [COORD_W_DEF-1:0]      coord_t;
    typedef logic signed [VEC_W_DEF-1:0] svec_t;

    typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} seq_state_e;

    localparam rgb12_t DEBUG_RGB = 12'hF00;
    localparam rgb12_t BLANK_RGB = 12'h000;

    // Right shift that turns the k*vec accumulator into k*vec/N_MARKERS.
    function automatic int mark_shift(input int n_markers);
        return $clog2(n_markers);
    endfunction

endpackage

// File: rtl/ray_marker_gen.sv
// Per-frame snapshot of player/ray state and vblank sequencer that precomputes the
// N_MARKERS+1 ray marker points into a pending set, then commits them to the active set.
module ray_marker_gen
    import compositor_pkg::*;
#(
    parameter int N_MARKERS = 8,
    parameter int COORD_W   = 10,
    parameter int VEC_W     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      frame_start_i,
    input  logic [COORD_W-1:0]        x_i,
    input  logic [COORD_W-1:0]        y_i,
    input  logic [COORD_W-1:0]        size_i,
    input  logic signed [VEC_W-1:0]   x_vec_i,
    input  logic signed [VEC_W-1:0]   y_vec_i,
    output logic [COORD_W-1:0]        sh_x_o,
    output logic [COORD_W-1:0]        sh_y_o,
    output logic [COORD_W-1:0]        sh_size_o,
    output logic signed [COORD_W+1:0] mark_x_o [N_MARKERS+1],
    output logic signed [COORD_W+1:0] mark_y_o [N_MARKERS+1],
    output logic                      mark_vld_o,
    output logic                      busy_o
);

    localparam int SHIFT = mark_shift(N_MARKERS);
    localparam int AW    = VEC_W + SHIFT + 1;
    localparam int MW    = COORD_W + 2;
    localparam int NM    = N_MARKERS + 1;
    localparam int KW    = $clog2(NM);
    localparam logic [KW-1:0] K_LAST = KW'(N_MARKERS);

    seq_state_e              state_q;
    logic [KW-1:0]           k_q;
    logic signed [AW-1:0]    acc_x_q, acc_y_q;
    logic signed [AW-1:0]    vx_ext, vy_ext, off_x, off_y;
    logic                    busy_q, act_vld_q, snap_vld_q;
    logic [COORD_W-1:0]      sh_x_q, sh_y_q, sh_size_q;
    logic signed [VEC_W-1:0] sh_xv_q, sh_yv_q;
    logic signed [MW-1:0]    mx_d, my_d;
    logic signed [MW-1:0]    pend_x_q [NM];
    logic signed [MW-1:0]    pend_y_q [NM];
    logic signed [MW-1:0]    act_x_q  [NM];
    logic signed [MW-1:0]    act_y_q  [NM];

    assign vx_ext = {{(AW-VEC_W){sh_xv_q[VEC_W-1]}}, sh_xv_q};
    assign vy_ext = {{(AW-VEC_W){sh_yv_q[VEC_W-1]}}, sh_yv_q};
    assign off_x  = acc_x_q >>> SHIFT;
    assign off_y  = acc_y_q >>> SHIFT;
    assign mx_d   = $signed({2'b00, sh_x_q}) + MW'(off_x);
    assign my_d   = $signed({2'b00, sh_y_q}) + MW'(off_y);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            k_q        <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            busy_q     <= 1'b0;
            act_vld_q  <= 1'b0;
            snap_vld_q <= 1'b0;
        end else if (frame_start_i) begin
            // A new frame always restarts the walk from k=0; the active set is left alone.
            state_q    <= ACCUM;
            k_q        <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            busy_q     <= 1'b1;
            snap_vld_q <= 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    acc_x_q <= acc_x_q + vx_ext;
                    acc_y_q <= acc_y_q + vy_ext;
                    if (k_q == K_LAST) state_q <= COMMIT;
                    else               k_q     <= k_q + 1'b1;
                end
                COMMIT: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    act_vld_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Until the first frame_start the shadow tracks the live inputs so the player is visible.
    always_ff @(posedge clk_i) begin
        if (frame_start_i || !snap_vld_q) begin
            sh_x_q    <= x_i;
            sh_y_q    <= y_i;
            sh_size_q <= size_i;
            sh_xv_q   <= x_vec_i;
            sh_yv_q   <= y_vec_i;
        end
        if (!frame_start_i && state_q == ACCUM) begin
            pend_x_q[k_q] <= mx_d;
            pend_y_q[k_q] <= my_d;
        end
        if (!frame_start_i && state_q == COMMIT) begin
            act_x_q <= pend_x_q;
            act_y_q <= pend_y_q;
        end
    end

    assign sh_x_o     = sh_x_q;
    assign sh_y_o     = sh_y_q;
    assign sh_size_o  = sh_size_q;
    assign mark_x_o   = act_x_q;
    assign mark_y_o   = act_y_q;
    assign mark_vld_o = act_vld_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/pixel_compositor.sv
// Three-stage pixel compositor: debug > ray marker > player disc > wall > background.
// The debug layer and its debugX/debugY ports exist only when DEBUG_MARKER_EN is defined.
module pixel_compositor
    import compositor_pkg::*;
#(
    parameter int          N_MARKERS  = 8,
    parameter int          RAY_W      = 1,
    parameter int          COORD_W    = COORD_W_DEF,
    parameter int          VEC_W      = VEC_W_DEF,
    parameter logic [11:0] PLAYER_RGB = 12'hF70,
    parameter logic [11:0] RAY_RGB    = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h004
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_start,
    input  logic                    pix_valid_in,
    input  logic [COORD_W-1:0]      DrawX,
    input  logic [COORD_W-1:0]      DrawY,
    input  logic [COORD_W-1:0]      X,
    input  logic [COORD_W-1:0]      Y,
    input  logic [COORD_W-1:0]      size,
    input  logic signed [VEC_W-1:0] x_vec,
    input  logic signed [VEC_W-1:0] y_vec,
    input  logic                    wall_on,
    input  logic [11:0]             wall_color,
`ifdef DEBUG_MARKER_EN
    input  logic [COORD_W-1:0]      debugX,
    input  logic [COORD_W-1:0]      debugY,
`endif
    output logic [3:0]              Red,
    output logic [3:0]              Green,
    output logic [3:0]              Blue,
    output logic                    pix_valid_out,
    output logic                    busy
);

    localparam int MW   = COORD_W + 2;
    localparam int NM   = N_MARKERS + 1;
    localparam int SQ_W = 2 * COORD_W + 1;
    localparam logic signed [MW-1:0] RAY_HW = MW'(RAY_W);
`ifdef DEBUG_MARKER_EN
    localparam logic signed [MW-1:0] DBG_HW = MW'(RAY_W + 1);
`endif

    function automatic logic [COORD_W-1:0] mag(input logic signed [COORD_W:0] v);
        logic signed [COORD_W:0] a;
        a = (v < 0) ? -v : v;
        return COORD_W'(a);
    endfunction

    function automatic logic [SQ_W-1:0] sq(input logic [COORD_W-1:0] v);
        return SQ_W'(v) * SQ_W'(v);
    endfunction

    // Signed distance test; the extra bits keep screen edges from wrapping onto each other.
    function automatic logic near(input logic [COORD_W-1:0] p, input logic signed [MW-1:0] m,
                                  input logic signed [MW-1:0] hw);
        logic signed [MW-1:0] d;
        d = $signed({2'b00, p}) - m;
        return (d >= -hw) && (d <= hw);
    endfunction

    logic [COORD_W-1:0]   sh_x, sh_y, sh_size;
    logic signed [MW-1:0] mk_x [NM];
    logic signed [MW-1:0] mk_y [NM];
    logic                 mk_vld;

    ray_marker_gen #(
        .N_MARKERS(N_MARKERS),
        .COORD_W  (COORD_W),
        .VEC_W    (VEC_W)
    ) u_gen (
        .clk_i        (Clk),
        .rst_ni       (Reset_n),
        .frame_start_i(frame_start),
        .x_i          (X),
        .y_i          (Y),
        .size_i       (size),
        .x_vec_i      (x_vec),
        .y_vec_i      (y_vec),
        .sh_x_o       (sh_x),
        .sh_y_o       (sh_y),
        .sh_size_o    (sh_size),
        .mark_x_o     (mk_x),
        .mark_y_o     (mk_y),
        .mark_vld_o   (mk_vld),
        .busy_o       (busy)
    );

    logic                    vld_p1_q, vld_p2_q, vld_out_q;
    logic [COORD_W-1:0]      drx_p1_q, dry_p1_q, size_p1_q;
    logic signed [COORD_W:0] dx_p1_q, dy_p1_q;
    logic                    wall_on_p1_q, wall_on_p2_q;
    rgb12_t                  wall_p1_q, wall_p2_q;
    logic                    ply_hit_d, ray_hit_d, ply_hit_p2_q, ray_hit_p2_q;
    rgb12_t                  rgb_d, rgb_q;
`ifdef DEBUG_MARKER_EN
    logic [COORD_W-1:0]      dbgx_p1_q, dbgy_p1_q;
    logic                    dbg_hit_d, dbg_hit_p2_q;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_out_q <= 1'b0;
            rgb_q     <= BLANK_RGB;
        end else begin
            vld_p1_q  <= pix_valid_in;
            vld_p2_q  <= vld_p1_q;
            vld_out_q <= vld_p2_q;
            rgb_q     <= rgb_d;
        end
    end

    // Stage 1: capture pixel, offsets from the snapshotted player centre.
    always_ff @(posedge Clk) begin
        drx_p1_q     <= DrawX;
        dry_p1_q     <= DrawY;
        dx_p1_q      <= $signed({1'b0, DrawX}) - $signed({1'b0, sh_x});
        dy_p1_q      <= $signed({1'b0, DrawY}) - $signed({1'b0, sh_y});
        size_p1_q    <= sh_size;
        wall_on_p1_q <= wall_on;
        wall_p1_q    <= wall_color;
`ifdef DEBUG_MARKER_EN
        dbgx_p1_q    <= debugX;
        dbgy_p1_q    <= debugY;
`endif
    end

    // Stage 2: disc and marker hit tests.
    always_comb begin
        ply_hit_d = (sq(mag(dx_p1_q)) + sq(mag(dy_p1_q))) <= sq(size_p1_q);
        ray_hit_d = 1'b0;
        for (int i = 0; i < NM; i++) begin
            ray_hit_d = ray_hit_d | (mk_vld && near(drx_p1_q, mk_x[i], RAY_HW)
                                            && near(dry_p1_q, mk_y[i], RAY_HW));
        end
`ifdef DEBUG_MARKER_EN
        dbg_hit_d = near(drx_p1_q, $signed({2'b00, dbgx_p1_q}), DBG_HW)
                 && near(dry_p1_q, $signed({2'b00, dbgy_p1_q}), DBG_HW);
`endif
    end

    always_ff @(posedge Clk) begin
        ply_hit_p2_q <= ply_hit_d;
        ray_hit_p2_q <= ray_hit_d;
        wall_on_p2_q <= wall_on_p1_q;
        wall_p2_q    <= wall_p1_q;
`ifdef DEBUG_MARKER_EN
        dbg_hit_p2_q <= dbg_hit_d;
`endif
    end

    // Stage 3: later assignments override earlier ones, so order encodes priority.
    always_comb begin
        rgb_d = rgb12_t'(BG_RGB);
        if (wall_on_p2_q) rgb_d = wall_p2_q;
        if (ply_hit_p2_q) rgb_d = rgb12_t'(PLAYER_RGB);
        if (ray_hit_p2_q) rgb_d = rgb12_t'(RAY_RGB);
`ifdef DEBUG_MARKER_EN
        if (dbg_hit_p2_q) rgb_d = DEBUG_RGB;
`endif
        if (!vld_p2_q)    rgb_d = BLANK_RGB;
    end

    assign Red           = rgb_q.r;
    assign Green         = rgb_q.g;
    assign Blue          = rgb_q.b;
    assign pix_valid_out = vld_out_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: reset, player disc, marker sequencing, restart, edges, blanking.
module tb_pixel_compositor;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              pix_valid_in = 1'b0;
    logic [9:0]        DrawX = '0, DrawY = '0;
    logic [9:0]        X = 10'd100, Y = 10'd100, size = 10'd4;
    logic signed [7:0] x_vec = '0, y_vec = '0;
    logic              wall_on = 1'b0;
    logic [11:0]       wall_color = 12'hABC;
`ifdef DEBUG_MARKER_EN
    logic [9:0]        debugX = 10'd900, debugY = 10'd900;
`endif
    logic [3:0]        Red, Green, Blue;
    logic              pix_valid_out, busy;

    int total = 0;
    int bad   = 0;
    int cnt;

    pixel_compositor dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .pix_valid_in (pix_valid_in),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .X            (X),
        .Y            (Y),
        .size         (size),
        .x_vec        (x_vec),
        .y_vec        (y_vec),
        .wall_on      (wall_on),
        .wall_color   (wall_color),
`ifdef DEBUG_MARKER_EN
        .debugX       (debugX),
        .debugY       (debugY),
`endif
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .pix_valid_out(pix_valid_out),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pix_chk(input string tag, input int px, input int py, input logic w,
                           input logic [11:0] exp);
        DrawX        = 10'(px);
        DrawY        = 10'(py);
        wall_on      = w;
        pix_valid_in = 1'b1;
        tick(); tick(); tick();
        chk(tag, {20'h0, Red, Green, Blue}, {20'h0, exp});
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then player drawn from live inputs before any frame_start
        tick(); tick();
        chk("rst_rgb", {20'h0, Red, Green, Blue}, 32'h0);
        chk("rst_pvo", {31'h0, pix_valid_out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        Reset_n = 1'b1;
        tick();
        pix_chk("player_centre", 100, 100, 1'b0, 12'hF70);
        chk("pvo_active", {31'h0, pix_valid_out}, 32'h1);
        pix_chk("player_edge_in", 104, 100, 1'b0, 12'hF70);
        pix_chk("player_edge_out", 104, 101, 1'b0, 12'h004);
        pix_chk("no_marker_origin", 0, 0, 1'b0, 12'h004);
        pix_chk("player_over_wall", 100, 100, 1'b1, 12'hF70);
        pix_chk("wall_over_bg", 110, 100, 1'b1, 12'hABC);

        // 2: horizontal ray, markers at x=200,208..264, y=200
        X = 10'd200; Y = 10'd200; size = 10'd4; x_vec = 8'sd64; y_vec = 8'sd0;
        frame();
        wait_idle(cnt);
        chk("busy_len", cnt, 10);
        pix_chk("marker_k8", 264, 201, 1'b0, 12'hFFF);
        pix_chk("past_marker_k8", 266, 200, 1'b0, 12'h004);
        pix_chk("marker_k1", 208, 199, 1'b0, 12'hFFF);
        pix_chk("ray_over_player", 200, 200, 1'b0, 12'hFFF);

        // 3: negative vector, floor shift puts k=1 at (49,108), k=2 at (48,116)
        X = 10'd50; Y = 10'd100; size = 10'd2; x_vec = -8'sd7; y_vec = 8'sd64;
        frame();
        wait_idle(cnt);
        pix_chk("floor_k1", 49, 108, 1'b0, 12'hFFF);
        pix_chk("floor_k1_left", 48, 108, 1'b0, 12'hFFF);
        pix_chk("floor_k1_right", 51, 108, 1'b0, 12'h004);

        // 4: restart at k=4; old set kept, aborted set never committed
        X = 10'd300; Y = 10'd300; size = 10'd2; x_vec = 8'sd0; y_vec = 8'sd64;
        DrawX = 10'd48; DrawY = 10'd108; wall_on = 1'b0; pix_valid_in = 1'b1;
        frame();
        tick(); tick();
        chk("old_set_during_accum", {20'h0, Red, Green, Blue}, 32'hFFF);
        tick(); tick();
        x_vec = 8'sd64; y_vec = 8'sd0;
        frame();
        pix_chk("old_set_after_restart", 48, 108, 1'b0, 12'hFFF);
        pix_chk("aborted_set_hidden", 300, 332, 1'b0, 12'h004);
        wait_idle(cnt);
        chk("restart_busy_len", cnt + 6, 10);
        pix_chk("new_set_k8", 364, 300, 1'b0, 12'hFFF);
        pix_chk("aborted_k8_absent", 300, 364, 1'b0, 12'h004);
        pix_chk("old_set_replaced", 48, 108, 1'b0, 12'h004);

        // 5: marker at x=0 must not wrap to x=1023
        X = 10'd0; Y = 10'd300; size = 10'd2; x_vec = 8'sd0; y_vec = 8'sd64;
        frame();
        wait_idle(cnt);
        pix_chk("no_wrap_wall", 1023, 300, 1'b1, 12'hABC);
        pix_chk("no_wrap_bg", 1023, 300, 1'b0, 12'h004);
        pix_chk("edge_marker_hit", 1, 300, 1'b1, 12'hFFF);

        // 6: blanking follows pix_valid 3 cycles later; async reset clears outputs at once
        DrawX = 10'd600; DrawY = 10'd600; wall_on = 1'b0;
        pix_valid_in = 1'b1; tick();
        pix_valid_in = 1'b0; tick();
        pix_valid_in = 1'b1; tick();
        chk("toggle_pvo_1", {31'h0, pix_valid_out}, 32'h1);
        chk("toggle_rgb_1", {20'h0, Red, Green, Blue}, 32'h004);
        tick();
        chk("toggle_pvo_0", {31'h0, pix_valid_out}, 32'h0);
        chk("toggle_rgb_blank", {20'h0, Red, Green, Blue}, 32'h000);
        tick();
        chk("toggle_pvo_2", {31'h0, pix_valid_out}, 32'h1);
        chk("toggle_rgb_2", {20'h0, Red, Green, Blue}, 32'h004);
        frame();
        chk("busy_before_reset", {31'h0, busy}, 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_rgb", {20'h0, Red, Green, Blue}, 32'h0);
        chk("async_rst_pvo", {31'h0, pix_valid_out}, 32'h0);
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        X = 10'd500; Y = 10'd500; size = 10'd2;
        tick();
        Reset_n = 1'b1;
        tick();
        pix_chk("reset_clears_markers", 1, 300, 1'b0, 12'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
